// File: rtl/fir_tdm_mac.sv
// fir_tdm_mac: time-multiplexed FIR filter. One shared multiply-accumulate
// walks all NTAPS taps per sample; coefficients sit in a runtime-writable
// register file. Valid/ready on input and output, arithmetic-shift scaling
// and output saturation.
// Optional build macro FIR_TDM_ROUND_EN: round-half-up before the shift
// (only effective when SHIFT > 0); otherwise plain truncating shift.
module fir_tdm_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 16,
  parameter int OUT_W  = 12,
  parameter int SHIFT  = 4,
  localparam int AW    = $clog2(NTAPS),
  localparam int ACC_W = DATA_W + COEF_W + $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam int PW = DATA_W + COEF_W;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] tap_q  [NTAPS];
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic signed [ACC_W-1:0]  acc_q;
  logic [AW-1:0]            idx_q;
  logic [OUT_W-1:0]         out_data_q;
  logic                     out_sat_q;
  logic                     out_valid_q;

  logic                     last;
  logic                     coef_wr;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W:0]    sum_ext;
  logic signed [ACC_W:0]    scaled;
  logic [ACC_W-OUT_W+1:0]   top;
  logic [OUT_W-1:0]         sat_data;
  logic                     sat_flag;

  assign last    = (idx_q == AW'(NTAPS - 1));
  assign coef_wr = (state_q == IDLE) && coef_we && ({1'b0, coef_addr} < (AW+1)'(NTAPS));

  // MAC datapath: product of the current tap, running sum, scale and clamp
  always_comb begin
    prod    = PW'(tap_q[idx_q]) * PW'(coef_q[idx_q]);
    sum     = acc_q + ACC_W'(prod);
`ifdef FIR_TDM_ROUND_EN
    // One extra bit of headroom so adding the half-LSB cannot wrap.
    sum_ext = (ACC_W+1)'(sum) + ((SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0))
                                             : (ACC_W+1)'(0));
`else
    sum_ext = (ACC_W+1)'(sum);
`endif
    scaled  = sum_ext >>> SHIFT;
    // In range exactly when every bit from the OUT_W sign bit upward agrees.
    top     = scaled[ACC_W:OUT_W-1];
    sat_flag = !((&top) || !(|top));
    if (!sat_flag)
      sat_data = scaled[OUT_W-1:0];
    else if (scaled[ACC_W])
      sat_data = {1'b1, {(OUT_W-1){1'b0}}};
    else
      sat_data = {1'b0, {(OUT_W-1){1'b1}}};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = MAC;
      MAC:     if (last)      state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; in_ready is held low while reset is asserted
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    if (state_q == IDLE) begin
      in_ready = rst_b;
      busy     = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Delay line, coefficient file, accumulator and output registers
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        tap_q[i]  <= '0;
        coef_q[i] <= '0;
      end
      acc_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (coef_wr) coef_q[coef_addr] <= coef_wdata;
      case (state_q)
        IDLE: if (in_valid) begin
          tap_q[0] <= in_data;
          for (int unsigned i = 1; i < NTAPS; i++) tap_q[i] <= tap_q[i-1];
          acc_q <= '0;
          idx_q <= '0;
        end
        MAC: begin
          acc_q <= sum;
          idx_q <= last ? '0 : idx_q + 1'b1;
          if (last) begin
            out_data_q  <= sat_data;
            out_sat_q   <= sat_flag;
            out_valid_q <= 1'b1;
          end
        end
        OUT: if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Scoreboard bench for fir_tdm_mac (NTAPS=4, SHIFT=4, OUT_W=12).
`timescale 1ns/1ps
module tb_fir_tdm_mac;
  localparam int N = 4, DW = 8, CW = 8, OW = 12, SH = 4, AW = 2;

  logic          clk = 1'b0, rst_b = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, out_ready = 1'b0, out_sat, busy;
  logic [OW-1:0] out_data;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_wdata = '0;

  int checks = 0, failures = 0;
  typedef struct {int d; bit s;} exp_t;
  exp_t sb[$];
  int   hist[N];
  int   mcoef[N];
  bit   rnd_on = 1'b0;

  always #5 clk = ~clk;

  fir_tdm_mac #(.DATA_W(DW), .COEF_W(CW), .NTAPS(N), .OUT_W(OW), .SHIFT(SH)) dut (
    .clk(clk), .rst_b(rst_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: dot product of sample history and coefficients, then scale/clamp.
  function automatic exp_t model();
    longint sum = 0, sc;
    longint maxv = (longint'(1) << (OW - 1)) - 1;
    longint minv = -(longint'(1) << (OW - 1));
    exp_t e;
    for (int i = 0; i < N; i++) sum += longint'(hist[i]) * longint'(mcoef[i]);
`ifdef FIR_TDM_ROUND_EN
    if (SH > 0) sum += longint'(1) << (SH - 1);
`endif
    sc = sum >>> SH;
    if (sc > maxv)      begin e.d = int'(maxv); e.s = 1'b1; end
    else if (sc < minv) begin e.d = int'(minv); e.s = 1'b1; end
    else                begin e.d = int'(sc);   e.s = 1'b0; end
    return e;
  endfunction

  // Coefficient write while the block is known to be idle.
  task automatic wr(input int a, input int d);
    coef_we = 1'b1; coef_addr = AW'(a); coef_wdata = CW'(d);
    @(posedge clk); #1;
    coef_we = 1'b0;
    mcoef[a] = d;
  endtask

  task automatic accept(input int x, input bit we, input int a, input int d, output bit ok);
    int n = 0;
    ok = 1'b0;
    in_valid = 1'b1; in_data = DW'(x);
    if (we) begin coef_we = 1'b1; coef_addr = AW'(a); coef_wdata = CW'(d); end
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      n++;
    end
    if (ok) begin
      if (we) mcoef[a] = d;
      for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = x;
      sb.push_back(model());
    end else begin
      checks++; failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    #1;
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  // Accept a sample, optionally writing a coefficient during the first MAC cycle,
  // and check in_ready/out_valid timing until the result appears.
  task automatic send(input int x, input bit we = 0, input int a = 0, input int d = 0,
                      input bit mac_we = 0, input int ma = 0, input int md = 0);
    bit ok;
    accept(x, we, a, d, ok);
    if (!ok) return;
    if (mac_we) begin coef_we = 1'b1; coef_addr = AW'(ma); coef_wdata = CW'(md); end
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      if (k == 2) coef_we = 1'b0;
      chk("latency_out_valid", int'(out_valid), int'(k == N + 1));
      chk("in_ready_low_busy", int'(in_ready), 0);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every output handshake is compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_b && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output: got %0d expected no output", $signed(out_data));
        end else begin
          e = sb.pop_front();
          chk("out_data", int'($signed(out_data)), e.d);
          chk("out_sat", int'(out_sat), int'(e.s));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_on) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t be;
    bit   ok;
    int   x;
    for (int i = 0; i < N; i++) begin hist[i] = 0; mcoef[i] = 0; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst_b = 1'b1; out_ready = 1'b1;

    // Impulse response
    wr(0, 16); wr(1, 32); wr(2, 48); wr(3, 64);
    send(1); send(0); send(0); send(0);
    chk("impulse_last", int'($signed(out_data)), 4);

    // Saturation both ways
    for (int i = 0; i < N; i++) wr(i, 127);
    repeat (N) send(127);
    chk("sat_pos_data", int'($signed(out_data)), 2047);
    chk("sat_pos_flag", int'(out_sat), 1);
    repeat (N) send(-128);
    chk("sat_neg_data", int'($signed(out_data)), -2048);
    chk("sat_neg_flag", int'(out_sat), 1);

    // Rounding versus truncation
    wr(0, 1); wr(1, 0); wr(2, 0); wr(3, 0);
    send(8);
`ifdef FIR_TDM_ROUND_EN
    chk("round_pos", int'($signed(out_data)), 1);
`else
    chk("round_pos", int'($signed(out_data)), 0);
`endif
    send(-8);
`ifdef FIR_TDM_ROUND_EN
    chk("round_neg", int'($signed(out_data)), 0);
`else
    chk("round_neg", int'($signed(out_data)), -1);
`endif

    // Backpressure: output held, pending sample not taken
    wr(0, 20); wr(1, -10); wr(2, 5); wr(3, 3);
    out_ready = 1'b0;
    send(37);
    be = sb[$];
    in_valid = 1'b1; in_data = DW'(-5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_data", int'($signed(out_data)), be.d);
      chk("bp_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(-5);

    // Coefficient write while busy is dropped; write coinciding with accept is used
    wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
    send(5, 0, 0, 0, 1, 0, 99);
    send(3);
    send(7, 1, 1, -50);

    // Reset in the middle of MAC
    accept(9, 0, 0, 0, ok);
    @(posedge clk); @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    if (ok) void'(sb.pop_back());
    for (int i = 0; i < N; i++) begin hist[i] = 0; mcoef[i] = 0; end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", int'(out_valid), 0);
      if (i == 0) begin
        chk("midrst_ready_after", int'(in_ready), 1);
        chk("midrst_busy_after", int'(busy), 0);
      end
      @(posedge clk); #1;
    end
    send(16);
    chk("midrst_coefs_zero", int'($signed(out_data)), 0);
    for (int i = 0; i < N; i++) wr(i, 16);
    send(0);
    chk("midrst_taps_zero", int'($signed(out_data)), 16);

    // Randomized traffic with random backpressure and coefficient updates
    rnd_on = 1'b1;
    repeat (40) begin
      x = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 1) == 1)
        send(x, 1, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)) - 128);
      else
        send(x);
    end
    rnd_on = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
